// File: rtl/wave_table_ram.sv
// ---------------------------------------------------------------------------
// wave_table_ram
//   Double-buffered (ping-pong) waveform table for the DDS datapath. The host
//   always loads the inactive bank while the phase-to-amplitude lookup reads
//   the active bank. A requested bank swap is deferred until a table boundary
//   (a read of the last address) or an idle read cycle, so one DDS period never
//   mixes samples from two different tables.
//
// Parameters
//   DATA_WIDTH : sample width in bits
//   ADDR_WIDTH : table address width; each bank holds 2**ADDR_WIDTH words
//   OUT_REG    : 1 adds an output register (read latency 2), 0 gives latency 1
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset (control and read pipeline)
//   wr_en        : host write strobe, always targets the inactive bank
//   wr_addr      : host write address
//   wr_data      : host write data
//   swap_req     : bank swap request (pulse or level)
//   swap_pending : swap requested but waiting for a table boundary
//   active_bank  : bank currently read by the DDS
//   rd_en        : DDS read strobe
//   rd_addr      : DDS read address (phase accumulator MSBs)
//   rd_data      : read sample, held while rd_valid is low
//   rd_valid     : rd_en delayed by the read latency
// ---------------------------------------------------------------------------
module wave_table_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int OUT_REG    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  swap_req,
  output logic                  swap_pending,
  output logic                  active_bank,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH + 1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_PEND = 1'b1;

  // A read of the last table address closes one DDS period.
  function automatic logic f_is_boundary(input logic                  en,
                                         input logic [ADDR_WIDTH-1:0] addr);
    f_is_boundary = en && (addr == {ADDR_WIDTH{1'b1}});
  endfunction

  // Storage: both banks in one array, physical address = {bank, addr}.
  // Contents are deliberately not reset.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  r_active_bank;
  logic                  r_state;
  logic                  w_state_nxt;
  logic                  w_toggle;
  logic                  w_swap_ok;

  logic [DATA_WIDTH-1:0] r_data_p0;
  logic                  r_vld_p0;

  // ---------------------------------------------------------------------------
  // Host write port: the bank is the pre-edge inactive one. On a swap edge this
  // is the bank that becomes active right after the edge, so the word is
  // visible to the very next read.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[{~r_active_bank, wr_addr}] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Swap control. A swap is safe when this edge is a boundary read or when the
  // DDS is not reading at all. Requests arriving while PENDING are absorbed.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_swap_ok   = f_is_boundary(rd_en, rd_addr) || !rd_en;
    w_state_nxt = r_state;
    w_toggle    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (swap_req) begin
          if (w_swap_ok) begin
            w_toggle = 1'b1;
          end else begin
            w_state_nxt = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (w_swap_ok) begin
          w_toggle    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_active_bank <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_toggle) begin
        r_active_bank <= ~r_active_bank;
      end
    end
  end

  assign swap_pending = (r_state == ST_PEND);
  assign active_bank  = r_active_bank;

  // ---------------------------------------------------------------------------
  // Stage p0: synchronous array read from the pre-edge active bank. The read
  // on a swap edge therefore still sees the old table. Data holds when idle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_p0 <= '0;
      r_vld_p0  <= 1'b0;
    end else begin
      r_vld_p0 <= rd_en;
      if (rd_en) begin
        r_data_p0 <= r_mem[{r_active_bank, rd_addr}];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: optional output register. Only a valid word is forwarded so the
  // output keeps its last sample across idle cycles.
  // ---------------------------------------------------------------------------
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] r_data_p1;
      logic                  r_vld_p1;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data_p1 <= '0;
          r_vld_p1  <= 1'b0;
        end else begin
          r_vld_p1 <= r_vld_p0;
          if (r_vld_p0) begin
            r_data_p1 <= r_data_p0;
          end
        end
      end

      assign rd_data  = r_data_p1;
      assign rd_valid = r_vld_p1;
    end else begin : g_no_out_reg
      assign rd_data  = r_data_p0;
      assign rd_valid = r_vld_p0;
    end
  endgenerate

endmodule
